final_project_soc_mouse_buttons: RTL and testbench

Avalon-MM slave input PIO for the mouse push-buttons. It is the read-side counterpart of the mouseX/mouseY output PIOs. It synchronizes and debounces WIDTH asynchronous button lines, then exposes three things to the Nios II: the debounced level, a per-bit edge-capture register and a maskable interrupt. It sits on the SoC interconnect beside the other PIOs, with irq routed to the CPU interrupt controller.

---
 rtl/final_project_soc_mouse_buttons_if.sv | 19 +
 rtl/final_project_soc_mouse_buttons.sv | 90 +++++++++
 tb/tb_final_project_soc_mouse_buttons.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/final_project_soc_mouse_buttons_if.sv
// Avalon-MM slave bus plus interrupt line for the mouse-button input PIO.
interface final_project_soc_mouse_buttons_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/final_project_soc_mouse_buttons.sv
// Mouse-button input PIO: 2-flop sync + per-bit debounce, level/edge-capture/mask registers, level irq.
// Latency: db toggles 2+DEBOUNCE_CYCLES edges after an input change; zero-wait reads, no backpressure.
module final_project_soc_mouse_buttons #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int EDGE_TYPE       = 0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [WIDTH-1:0]                  in_port,
  final_project_soc_mouse_buttons_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [CNT_W-1:0] cnt [WIDTH];

  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] cap_set;
  logic [WIDTH-1:0] cap_clr;
  logic             wr_en;
  logic [31:0]      rd;
  logic             unused_wd;

  always_comb begin
    toggle = '0;
    for (int i = 0; i < WIDTH; i++) begin
      toggle[i] = (sync2[i] != db[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign rise    = toggle & ~db;
  assign fall    = toggle & db;
  assign cap_set = (EDGE_TYPE == 0) ? rise :
                   (EDGE_TYPE == 1) ? fall : toggle;

  assign wr_en   = bus.chipselect && !bus.write_n;
  assign cap_clr = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      db    <= db ^ toggle;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == db[i] || toggle[i]) cnt[i] <= '0;
        else                                cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // A capture set on the same edge as a write-1-to-clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && bus.address == 2'd2) irq_mask <= bus.writedata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~cap_clr) | cap_set;
    end
  end

  always_comb begin
    rd = '0;
    case (bus.address)
      2'd0:    rd[WIDTH-1:0] = db;
      2'd2:    rd[WIDTH-1:0] = irq_mask;
      2'd3:    rd[WIDTH-1:0] = edge_capture;
      default: rd = '0;
    endcase
  end

  assign bus.readdata = rd;
  assign bus.irq      = |(edge_capture & irq_mask);
  assign unused_wd    = ^bus.writedata;

endmodule

// File: tb/tb_final_project_soc_mouse_buttons.sv
// Bench for the mouse-button PIO: three instances (rising, falling, either edge) with DEBOUNCE_CYCLES=4.
module tb_final_project_soc_mouse_buttons;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] in0 = '0;
  logic [2:0] in1 = '0;
  logic [2:0] in2 = '0;
  int         n_assert = 0;
  int         n_fail = 0;
  exp_t       exp_q[$];

  final_project_soc_mouse_buttons_if b0 ();
  final_project_soc_mouse_buttons_if b1 ();
  final_project_soc_mouse_buttons_if b2 ();

  final_project_soc_mouse_buttons #(.WIDTH(3), .DEBOUNCE_CYCLES(4), .CNT_W(18), .EDGE_TYPE(0))
    dut0 (.clk(clk), .reset_n(reset_n), .in_port(in0), .bus(b0));
  final_project_soc_mouse_buttons #(.WIDTH(3), .DEBOUNCE_CYCLES(4), .CNT_W(18), .EDGE_TYPE(1))
    dut1 (.clk(clk), .reset_n(reset_n), .in_port(in1), .bus(b1));
  final_project_soc_mouse_buttons #(.WIDTH(3), .DEBOUNCE_CYCLES(4), .CNT_W(18), .EDGE_TYPE(2))
    dut2 (.clk(clk), .reset_n(reset_n), .in_port(in2), .bus(b2));

  always #5 clk = ~clk;

  task automatic push_exp(input string n, input logic [31:0] v);
    exp_t t;
    t.name = n;
    t.val  = v;
    exp_q.push_back(t);
  endtask

  task automatic bus_idle();
    b0.address = '0; b0.chipselect = 1'b0; b0.write_n = 1'b1; b0.writedata = '0;
    b1.address = '0; b1.chipselect = 1'b0; b1.write_n = 1'b1; b1.writedata = '0;
    b2.address = '0; b2.chipselect = 1'b0; b2.write_n = 1'b1; b2.writedata = '0;
  endtask

  // Combinational read: set the address, let it settle, sample.
  task automatic bus_read(input int d, input logic [1:0] a, output logic [31:0] rd, output logic iq);
    case (d)
      0: begin b0.address = a; #1; rd = b0.readdata; iq = b0.irq; end
      1: begin b1.address = a; #1; rd = b1.readdata; iq = b1.irq; end
      default: begin b2.address = a; #1; rd = b2.readdata; iq = b2.irq; end
    endcase
  endtask

  // Write lands on the next rising edge; returns #1 after it.
  task automatic bus_write(input int d, input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    case (d)
      0: begin b0.address = a; b0.writedata = v; b0.chipselect = 1'b1; b0.write_n = 1'b0; end
      1: begin b1.address = a; b1.writedata = v; b1.chipselect = 1'b1; b1.write_n = 1'b0; end
      default: begin b2.address = a; b2.writedata = v; b2.chipselect = 1'b1; b2.write_n = 1'b0; end
    endcase
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        iq;
    exp_t        e;
    bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      for (int a = 0; a < 4; a++) begin
        push_exp($sformatf("reset_rd_dut%0d_addr%0d", d, a), 32'h0);
        push_exp($sformatf("reset_irq_dut%0d_addr%0d", d, a), 32'h0);
        bus_read(d, 2'(a), rd, iq);
        e = exp_q.pop_front(); n_assert++;
        if (rd !== e.val) begin n_fail++; $display("FAIL %s: observed 0x%08h expected 0x%08h", e.name, rd, e.val); end
        e = exp_q.pop_front(); n_assert++;
        if ({31'b0, iq} !== e.val) begin n_fail++; $display("FAIL %s: observed %0b expected %0d", e.name, iq, e.val); end
      end
    end
  endtask

  task automatic test_debounce_latency();
    logic [31:0] rd;
    logic        iq;
    exp_t        e;
    @(negedge clk);
    in0 = 3'b001;
    push_exp("lat_data_edge4", 32'h0);
    push_exp("lat_data_edge5", 32'h1);
    push_exp("lat_capture", 32'h1);
    push_exp("lat_irq_masked", 32'h0);
    repeat (5) @(posedge clk);
    #1;
    bus_read(0, 2'd0, rd, iq);
    e = exp_q.pop_front(); n_assert++;
    if (rd !== e.val) begin n_fail++; $display("FAIL %s: observed 0x%08h expected 0x%08h", e.name, rd, e.val); end
    @(posedge clk);
    #1;
    bus_read(0, 2'd0, rd, iq);
    e = exp_q.pop_front(); n_assert++;
    if (rd !== e.val) begin n_fail++; $display("FAIL %s: observed 0x%08h expected 0x%08h", e.name, rd, e.val); end
    bus_read(0, 2'd3, rd, iq);
    e = exp_q.pop_front(); n_assert++;
    if (rd !== e.val) begin n_fail++; $display("FAIL %s: observed 0x%08h expected 0x%08h", e.name, rd, e.val); end
    e = exp_q.pop_front(); n_assert++;
    if ({31'b0, iq} !== e.val) begin n_fail++; $display("FAIL %s: observed %0b expected %0d", e.name, iq, e.val); end
  endtask

  task automatic test_registers();
    logic [31:0] rd;
    logic        iq;
    exp_t        e;
    logic [1:0]  wa [5] = '{2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
    logic [31:0] wd [5] = '{32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [1:0]  ra [5] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    logic [31:0] rv [5] = '{32'h1, 32'h0, 32'h7, 32'h0, 32'h1};
    logic        ri [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      push_exp($sformatf("reg_rd_step%0d", k), rv[k]);
      push_exp($sformatf("reg_irq_step%0d", k), {31'b0, ri[k]});
      bus_write(0, wa[k], wd[k]);
      bus_read(0, ra[k], rd, iq);
      e = exp_q.pop_front(); n_assert++;
      if (rd !== e.val) begin n_fail++; $display("FAIL %s: observed 0x%08h expected 0x%08h", e.name, rd, e.val); end
      e = exp_q.pop_front(); n_assert++;
      if ({31'b0, iq} !== e.val) begin n_fail++; $display("FAIL %s: observed %0b expected %0d", e.name, iq, e.val); end
    end
    bus_write(0, 2'd2, 32'h1);
    push_exp("reg_mask_restored", 32'h1);
    bus_read(0, 2'd2, rd, iq);
    e = exp_q.pop_front(); n_assert++;
    if (rd !== e.val) begin n_fail++; $display("FAIL %s: observed 0x%08h expected 0x%08h", e.name, rd, e.val); end
  endtask

  task automatic test_glitch();
    logic [31:0] rd;
    logic        iq;
    exp_t        e;
    push_exp("glitch_data", 32'h1);
    push_exp("glitch_capture", 32'h0);
    // Two 3-cycle pulses with a 1-cycle gap: only passes if the gap clears the counter.
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      in0[1] = 1'b1;
      repeat (3) @(negedge clk);
      in0[1] = 1'b0;
    end
    repeat (10) @(negedge clk);
    bus_read(0, 2'd0, rd, iq);
    e = exp_q.pop_front(); n_assert++;
    if (rd !== e.val) begin n_fail++; $display("FAIL %s: observed 0x%08h expected 0x%08h", e.name, rd, e.val); end
    bus_read(0, 2'd3, rd, iq);
    e = exp_q.pop_front(); n_assert++;
    if (rd !== e.val) begin n_fail++; $display("FAIL %s: observed 0x%08h expected 0x%08h", e.name, rd, e.val); end
  endtask

  task automatic test_edge_types();
    logic [31:0] rd;
    logic        iq;
    exp_t        e;
    for (int d = 1; d < 3; d++) begin
      push_exp($sformatf("edge%0d_press_data", d), 32'h4);
      push_exp($sformatf("edge%0d_press_cap", d), (d == 2) ? 32'h4 : 32'h0);
      push_exp($sformatf("edge%0d_release_data", d), 32'h0);
      push_exp($sformatf("edge%0d_release_cap", d), 32'h4);
      @(negedge clk);
      if (d == 1) in1[2] = 1'b1; else in2[2] = 1'b1;
      repeat (10) @(negedge clk);
      bus_read(d, 2'd0, rd, iq);
      e = exp_q.pop_front(); n_assert++;
      if (rd !== e.val) begin n_fail++; $display("FAIL %s: observed 0x%08h expected 0x%08h", e.name, rd, e.val); end
      bus_read(d, 2'd3, rd, iq);
      e = exp_q.pop_front(); n_assert++;
      if (rd !== e.val) begin n_fail++; $display("FAIL %s: observed 0x%08h expected 0x%08h", e.name, rd, e.val); end
      bus_write(d, 2'd3, 32'hFFFF_FFFF);
      @(negedge clk);
      if (d == 1) in1[2] = 1'b0; else in2[2] = 1'b0;
      repeat (10) @(negedge clk);
      bus_read(d, 2'd0, rd, iq);
      e = exp_q.pop_front(); n_assert++;
      if (rd !== e.val) begin n_fail++; $display("FAIL %s: observed 0x%08h expected 0x%08h", e.name, rd, e.val); end
      bus_read(d, 2'd3, rd, iq);
      e = exp_q.pop_front(); n_assert++;
      if (rd !== e.val) begin n_fail++; $display("FAIL %s: observed 0x%08h expected 0x%08h", e.name, rd, e.val); end
    end
  endtask

  task automatic test_set_wins_and_reset();
    logic [31:0] rd;
    logic        iq;
    exp_t        e;
    // Falling edge on the rising-edge instance: db clears, nothing captured.
    push_exp("fall_data", 32'h0);
    push_exp("fall_cap", 32'h0);
    @(negedge clk);
    in0[0] = 1'b0;
    repeat (10) @(negedge clk);
    bus_read(0, 2'd0, rd, iq);
    e = exp_q.pop_front(); n_assert++;
    if (rd !== e.val) begin n_fail++; $display("FAIL %s: observed 0x%08h expected 0x%08h", e.name, rd, e.val); end
    bus_read(0, 2'd3, rd, iq);
    e = exp_q.pop_front(); n_assert++;
    if (rd !== e.val) begin n_fail++; $display("FAIL %s: observed 0x%08h expected 0x%08h", e.name, rd, e.val); end
    // Rising toggle lands on edge 5; the clear write is aimed at the same edge.
    push_exp("setwins_cap", 32'h1);
    push_exp("setwins_irq", 32'h1);
    @(negedge clk);
    in0[0] = 1'b1;
    repeat (5) @(posedge clk);
    bus_write(0, 2'd3, 32'h1);
    bus_read(0, 2'd3, rd, iq);
    e = exp_q.pop_front(); n_assert++;
    if (rd !== e.val) begin n_fail++; $display("FAIL %s: observed 0x%08h expected 0x%08h", e.name, rd, e.val); end
    e = exp_q.pop_front(); n_assert++;
    if ({31'b0, iq} !== e.val) begin n_fail++; $display("FAIL %s: observed %0b expected %0d", e.name, iq, e.val); end
    // Release, then reset partway through the next press.
    @(negedge clk);
    in0[0] = 1'b0;
    repeat (10) @(negedge clk);
    in0[0] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    for (int a = 0; a < 4; a++) begin
      push_exp($sformatf("async_rst_rd_addr%0d", a), 32'h0);
      push_exp($sformatf("async_rst_irq_addr%0d", a), 32'h0);
      bus_read(0, 2'(a), rd, iq);
      e = exp_q.pop_front(); n_assert++;
      if (rd !== e.val) begin n_fail++; $display("FAIL %s: observed 0x%08h expected 0x%08h", e.name, rd, e.val); end
      e = exp_q.pop_front(); n_assert++;
      if ({31'b0, iq} !== e.val) begin n_fail++; $display("FAIL %s: observed %0b expected %0d", e.name, iq, e.val); end
    end
    push_exp("post_rst_data_edge4", 32'h0);
    push_exp("post_rst_data_edge5", 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus_read(0, 2'd0, rd, iq);
    e = exp_q.pop_front(); n_assert++;
    if (rd !== e.val) begin n_fail++; $display("FAIL %s: observed 0x%08h expected 0x%08h", e.name, rd, e.val); end
    @(posedge clk);
    #1;
    bus_read(0, 2'd0, rd, iq);
    e = exp_q.pop_front(); n_assert++;
    if (rd !== e.val) begin n_fail++; $display("FAIL %s: observed 0x%08h expected 0x%08h", e.name, rd, e.val); end
  endtask

  initial begin
    test_reset();
    test_debounce_latency();
    test_registers();
    test_glitch();
    test_edge_types();
    test_set_wins_and_reset();
    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
